// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_unit_if
// Fetch-side bundle: backend redirect, instruction queue push, imem read port.
// Revision: 1.0
// ============================================================================
interface fetch_unit_if #(
   parameter int XLEN = 32
) ();
   logic            flush;
   logic [XLEN-1:0] flush_pc;
   logic            iq_full;
   logic            iq_write;
   logic [XLEN-1:0] iq_wdata;
   logic [XLEN-1:0] iq_pc;
   logic [XLEN-1:0] imem_addr;
   logic [3:0]      imem_rmask;
   logic [XLEN-1:0] imem_rdata;
   logic            imem_resp;
   logic [15:0]     discard_cnt;

   modport master (
      input  flush, flush_pc, iq_full, imem_rdata, imem_resp,
      output iq_write, iq_wdata, iq_pc, imem_addr, imem_rmask, discard_cnt
   );

   modport slave (
      output flush, flush_pc, iq_full, imem_rdata, imem_resp,
      input  iq_write, iq_wdata, iq_pc, imem_addr, imem_rmask, discard_cnt
   );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit
// Instruction-queue producer: one outstanding imem read, flush redirect/discard.
// Revision: 1.0
// ============================================================================
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000
) (
   input  wire logic    clk,
   input  wire logic    rst,
   fetch_unit_if.master bus
);
   typedef enum logic [1:0] {
      REQ   = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state_q;
   logic            active_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] redirect_pc_q;
   logic [XLEN-1:0] hold_data_q;
   logic [XLEN-1:0] hold_pc_q;
   logic [15:0]     discard_cnt_q;

   logic [XLEN-1:0] w_flush_pc;
   logic [15:0]     w_discard_inc;
   logic            w_req_resp;

   assign w_flush_pc    = bus.flush_pc & ~(XLEN'(3));
   assign w_discard_inc = (discard_cnt_q == 16'hFFFF) ? discard_cnt_q : discard_cnt_q + 16'd1;
   assign w_req_resp    = (state_q == REQ) && active_q && bus.imem_resp;

   assign bus.iq_write    = !rst && !bus.flush && !bus.iq_full &&
                            (w_req_resp || (state_q == HOLD));
   assign bus.iq_wdata    = (state_q == HOLD) ? hold_data_q : bus.imem_rdata;
   assign bus.iq_pc       = (state_q == HOLD) ? hold_pc_q : pc_q;
   assign bus.imem_addr   = pc_q;
   assign bus.imem_rmask  = (!rst && (((state_q == REQ) && active_q) || (state_q == DRAIN)))
                            ? 4'hF : 4'h0;
   assign bus.discard_cnt = discard_cnt_q;

   // active_q low in REQ marks the idle bubble that follows every completed read
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= REQ;
         active_q      <= 1'b1;
         pc_q          <= RESET_PC;
         redirect_pc_q <= RESET_PC;
         hold_data_q   <= '0;
         hold_pc_q     <= '0;
         discard_cnt_q <= 16'd0;
      end else begin
         case (state_q)
            REQ: begin
               if (!active_q) begin
                  active_q <= 1'b1;
                  if (bus.flush) pc_q <= w_flush_pc;
               end else if (bus.flush) begin
                  if (bus.imem_resp) begin
                     pc_q          <= w_flush_pc;
                     discard_cnt_q <= w_discard_inc;
                     active_q      <= 1'b0;
                  end else begin
                     redirect_pc_q <= w_flush_pc;
                     state_q       <= DRAIN;
                  end
               end else if (bus.imem_resp) begin
                  if (!bus.iq_full) begin
                     pc_q     <= pc_q + XLEN'(4);
                     active_q <= 1'b0;
                  end else begin
                     hold_data_q <= bus.imem_rdata;
                     hold_pc_q   <= pc_q;
                     state_q     <= HOLD;
                  end
               end
            end
            DRAIN: begin
               if (bus.flush) redirect_pc_q <= w_flush_pc;
               if (bus.imem_resp) begin
                  pc_q          <= bus.flush ? w_flush_pc : redirect_pc_q;
                  discard_cnt_q <= w_discard_inc;
                  state_q       <= REQ;
                  active_q      <= 1'b0;
               end
            end
            HOLD: begin
               if (bus.flush) begin
                  pc_q     <= w_flush_pc;
                  state_q  <= REQ;
                  active_q <= 1'b1;
               end else if (!bus.iq_full) begin
                  pc_q     <= hold_pc_q + XLEN'(4);
                  state_q  <= REQ;
                  active_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= REQ;
               active_q <= 1'b1;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit
// Directed vector table, hand-written corner sequences, and a randomized run
// against a queue-level reference model of the fetch stream.
// Revision: 1.0
// ============================================================================
module tb_fetch_unit;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   fetch_unit_if #(.XLEN(32)) bus ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h1eceb000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        r;
      logic        f;
      logic [31:0] fpc;
      logic        full;
      logic        rsp;
      logic [31:0] rd;
      logic [1:0]  req;   // 0: rmask must be 0, 1: request at addr, 2: don't care
      logic [31:0] addr;
      logic        wr;
      logic [31:0] ipc;
      logic [31:0] wd;
      logic [15:0] dc;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic f, input logic [31:0] fpc,
                               input logic rsp, input logic [31:0] rd, input logic [1:0] req,
                               input logic [31:0] addr, input logic wr, input logic [31:0] ipc,
                               input logic [31:0] wd, input logic [15:0] dc);
      vec_t v;
      v.r = r; v.f = f; v.fpc = fpc; v.full = 1'b0; v.rsp = rsp; v.rd = rd;
      v.req = req; v.addr = addr; v.wr = wr; v.ipc = ipc; v.wd = wd; v.dc = dc;
      return v;
   endfunction

   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic apply(input logic r, input logic f, input logic [31:0] fpc,
                        input logic full, input logic rsp, input logic [31:0] rd);
      @(posedge clk);
      #1;
      rst            = r;
      bus.flush      = f;
      bus.flush_pc   = fpc;
      bus.iq_full    = full;
      bus.imem_resp  = rsp;
      bus.imem_rdata = rd;
      @(negedge clk);
   endtask

   task automatic step(input logic f, input logic [31:0] fpc, input logic full,
                       input logic rsp, input logic [31:0] rd);
      apply(1'b0, f, fpc, full, rsp, rd);
   endtask

   task automatic do_reset();
      apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   // idles until a request appears (bounded), then checks its address
   task automatic wait_req(input string nm, input logic [31:0] a);
      logic seen;
      logic wr_seen;
      seen    = 1'b0;
      wr_seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
         if (bus.iq_write) wr_seen = 1'b1;
         if (bus.imem_rmask == 4'hF) begin
            seen = 1'b1;
            chk({nm, " addr"}, bus.imem_addr, a);
         end
      end
      chk({nm, " request seen"}, {31'h0, seen}, 32'h1);
      chk({nm, " no enqueue"}, {31'h0, wr_seen}, 32'h0);
   endtask

   logic [31:0] exp_pc, prev_addr, fpc;
   logic [15:0] disc_exp;
   logic        held, stale, prev_pend, prev_resp, norm1, norm2, pend, f, full, rsp, ew;
   int          nenq;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      rst            = 1'b1;
      bus.flush      = 1'b0;
      bus.flush_pc   = 32'h0;
      bus.iq_full    = 1'b0;
      bus.imem_resp  = 1'b0;
      bus.imem_rdata = 32'h0;

      // reset, two fetches, then a flush two cycles into the third request
      tbl.push_back(mk(1, 0, 32'h0, 0, 32'h0, 2'd0, 32'h0, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb000, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb000, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 32'h00000013, 2'd1, 32'h1eceb000, 1, 32'h1eceb000, 32'h00000013, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd0, 32'h0, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb004, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb004, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 32'h00100093, 2'd1, 32'h1eceb004, 1, 32'h1eceb004, 32'h00100093, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd0, 32'h0, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb008, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb008, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 1, 32'h1eceb100, 0, 32'h0, 2'd1, 32'h1eceb008, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb008, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd1, 32'h1eceb008, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 1, 32'hcafef00d, 2'd1, 32'h1eceb008, 0, 32'h0, 32'h0, 16'd0));
      tbl.push_back(mk(0, 0, 32'h0, 0, 32'h0, 2'd2, 32'h0, 0, 32'h0, 32'h0, 16'd1));

      apply(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].f, tbl[i].fpc, tbl[i].full, tbl[i].rsp, tbl[i].rd);
         chk($sformatf("vec%0d iq_write", i), {31'h0, bus.iq_write}, {31'h0, tbl[i].wr});
         if (tbl[i].wr) begin
            chk($sformatf("vec%0d iq_pc", i), bus.iq_pc, tbl[i].ipc);
            chk($sformatf("vec%0d iq_wdata", i), bus.iq_wdata, tbl[i].wd);
         end
         if (tbl[i].req == 2'd0)
            chk($sformatf("vec%0d rmask", i), {28'h0, bus.imem_rmask}, 32'h0);
         if (tbl[i].req == 2'd1) begin
            chk($sformatf("vec%0d rmask", i), {28'h0, bus.imem_rmask}, 32'hF);
            chk($sformatf("vec%0d addr", i), bus.imem_addr, tbl[i].addr);
         end
         chk($sformatf("vec%0d discard_cnt", i), {16'h0, bus.discard_cnt}, {16'h0, tbl[i].dc});
      end
      wait_req("redirect after drain", 32'h1eceb100);

      // two flushes while draining: last one wins, drained word dropped
      step(1'b1, 32'h00000100, 1'b0, 1'b0, 32'h0);
      chk("drain f1 iq_write", {31'h0, bus.iq_write}, 32'h0);
      step(1'b1, 32'h00000200, 1'b0, 1'b0, 32'h0);
      chk("drain f2 addr held", bus.imem_addr, 32'h1eceb100);
      chk("drain f2 rmask", {28'h0, bus.imem_rmask}, 32'hF);
      step(1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678);
      chk("drain resp iq_write", {31'h0, bus.iq_write}, 32'h0);
      wait_req("last flush wins", 32'h00000200);
      chk("drain discard_cnt", {16'h0, bus.discard_cnt}, 32'd2);

      // flush coincident with response; low target bits are dropped
      step(1'b1, 32'h1eceb103, 1'b0, 1'b1, 32'h87654321);
      chk("flush+resp iq_write", {31'h0, bus.iq_write}, 32'h0);
      wait_req("flush+resp redirect", 32'h1eceb100);
      chk("flush+resp discard_cnt", {16'h0, bus.discard_cnt}, 32'd3);

      // iq_full at response: hold for 5 cycles, release enqueues once
      do_reset();
      wait_req("post reset", 32'h1eceb000);
      chk("reset discard_cnt", {16'h0, bus.discard_cnt}, 32'd0);
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'hdeadbeef);
      chk("full resp iq_write", {31'h0, bus.iq_write}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
         chk($sformatf("hold%0d rmask", i), {28'h0, bus.imem_rmask}, 32'h0);
         chk($sformatf("hold%0d iq_write", i), {31'h0, bus.iq_write}, 32'h0);
      end
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("release iq_write", {31'h0, bus.iq_write}, 32'h1);
      chk("release iq_pc", bus.iq_pc, 32'h1eceb000);
      chk("release iq_wdata", bus.iq_wdata, 32'hdeadbeef);
      wait_req("after release", 32'h1eceb004);

      // flush while holding: held word vanishes, not counted
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h11111111);
      chk("hold2 resp iq_write", {31'h0, bus.iq_write}, 32'h0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 32'h1eceb040, 1'b0, 1'b0, 32'h0);
      chk("hold flush iq_write", {31'h0, bus.iq_write}, 32'h0);
      wait_req("hold flush redirect", 32'h1eceb040);
      chk("hold flush discard_cnt", {16'h0, bus.discard_cnt}, 32'd0);

      // randomized run against a stream-level model
      do_reset();
      exp_pc = 32'h1eceb000; disc_exp = 16'd0; held = 1'b0; stale = 1'b0;
      prev_pend = 1'b0; prev_resp = 1'b0; prev_addr = 32'h0; norm1 = 1'b0; norm2 = 1'b0;
      nenq = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         rst  = 1'b0;
         pend = (bus.imem_rmask == 4'hF);
         if (pend && (!prev_pend || prev_resp)) chk("rnd request addr", bus.imem_addr, exp_pc);
         if (pend && prev_pend && !prev_resp) chk("rnd addr stable", bus.imem_addr, prev_addr);
         if (prev_pend && !prev_resp) chk("rnd no withdraw", {31'h0, pend}, 32'h1);
         if (held) chk("rnd no request while holding", {31'h0, pend}, 32'h0);
         if (norm1) chk("rnd bubble", {31'h0, pend}, 32'h0);
         if (norm2) chk("rnd restart", {31'h0, pend}, 32'h1);

         f    = ($urandom_range(0, 11) == 0);
         fpc  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                            : (32'h1ece_0000 | ($urandom & 32'hFFFF));
         full = ($urandom_range(0, 3) == 0);
         rsp  = pend && ($urandom_range(0, 2) == 0);
         bus.flush      = f;
         bus.flush_pc   = fpc;
         bus.iq_full    = full;
         bus.imem_resp  = rsp;
         bus.imem_rdata = rsp ? memword(bus.imem_addr) : $urandom;
         @(negedge clk);

         chk("rnd discard_cnt", {16'h0, bus.discard_cnt}, {16'h0, disc_exp});
         ew = !f && !full && ((rsp && !stale) || held);
         chk("rnd iq_write", {31'h0, bus.iq_write}, {31'h0, ew});
         if (ew) begin
            chk("rnd iq_pc", bus.iq_pc, exp_pc);
            chk("rnd iq_wdata", bus.iq_wdata, memword(exp_pc));
            nenq++;
         end

         norm2 = norm1;
         norm1 = rsp && !stale && !f && !full;
         if (rsp && (stale || f)) disc_exp = disc_exp + 16'd1;
         if (held) begin
            if (f || !full) held = 1'b0;
         end else if (rsp && !stale && !f && full) begin
            held = 1'b1;
         end
         if (pend && !rsp && f) stale = 1'b1;
         else if (rsp) stale = 1'b0;
         if (ew) exp_pc = exp_pc + 32'd4;
         if (f) exp_pc = fpc & ~32'h3;
         prev_pend = pend;
         prev_resp = rsp;
         prev_addr = bus.imem_addr;
      end
      chk("rnd enqueue progress", {31'h0, (nenq >= 100)}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
